// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU-side master and the mem_responder slave.
// The master drives the request strobe, address, direction and write data;
// the slave returns registered read data, a one-cycle ready pulse, an
// out-of-range flag and a busy indication.
interface mem_responder_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_err;
  logic        busy;

  modport master (
    output mem_req, mem_addr, mem_write, mem_write_data,
    input  mem_read_data, mem_ready, mem_err, busy
  );

  modport slave (
    input  mem_req, mem_addr, mem_write, mem_write_data,
    output mem_read_data, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder with a programmable number of wait cycles.
// A request accepted in IDLE is captured, waits WAIT cycles in WAIT_ST,
// then spends one cycle in RESP. The ready/err/read-data outputs are
// registered at the edge that ends RESP, so they appear in the following
// cycle, while the FSM is already back in IDLE and can accept the next
// request. Storage is updated at that same edge and is never reset.
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [31:0]       storage [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] index;
  logic              out_of_range;

  assign index        = addr_q[ADDR_W-1:0];
  assign out_of_range = (addr_q >> ADDR_W) != 32'd0;

  // Transaction FSM: capture, wait countdown, respond; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      addr_q            <= 32'd0;
      write_q           <= 1'b0;
      wdata_q           <= 32'd0;
      bus.mem_ready     <= 1'b0;
      bus.mem_err       <= 1'b0;
      bus.busy          <= 1'b0;
      bus.mem_read_data <= 32'd0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q   <= bus.mem_addr;
            write_q  <= bus.mem_write;
            wdata_q  <= bus.mem_write_data;
            cnt      <= WAIT_CNT;
            bus.busy <= 1'b1;
            if (WAIT_CNT == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT_ST;
            end
          end else begin
            bus.busy <= 1'b0;
          end
        end
        WAIT_ST: begin
          bus.busy <= 1'b1;
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.mem_ready <= 1'b1;
          bus.mem_err   <= out_of_range;
          if (!write_q) begin
            bus.mem_read_data <= out_of_range ? 32'd0 : storage[index];
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage write at the edge ending RESP; suppressed by reset or out-of-range.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && write_q && !out_of_range) begin
      storage[index] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with WAIT=2 and one
// with WAIT=0, compared against a word-array reference model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.ADDR_W(10), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_responder #(.ADDR_W(10), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: index 0 = WAIT=2 instance, index 1 = WAIT=0 instance.
  logic [31:0] model   [0:1][0:1023];
  bit          known   [0:1][0:1023];
  logic [31:0] last_rd [0:1];
  bit          last_ok [0:1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int sel);
    return (sel == 1) ? 0 : 2;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? bus0.mem_ready : bus2.mem_ready;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 1) ? bus0.mem_err : bus2.mem_err;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus0.busy : bus2.busy;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 1) ? bus0.mem_read_data : bus2.mem_read_data;
  endfunction

  task automatic drive(input int sel, input logic req, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    if (sel == 1) begin
      bus0.mem_req = req; bus0.mem_addr = a; bus0.mem_write = w; bus0.mem_write_data = d;
    end else begin
      bus2.mem_req = req; bus2.mem_addr = a; bus2.mem_write = w; bus2.mem_write_data = d;
    end
  endtask

  // Model-side checks of one response and model update.
  task automatic score(input int sel, input logic [31:0] a, input logic w, input logic [31:0] d);
    bit oor = (a >> 10) != 32'd0;
    int idx = int'(a[9:0]);
    check("err", {31'd0, get_err(sel)}, {31'd0, oor});
    if (w) begin
      if (last_ok[sel]) check("wr_rdata_hold", get_rdata(sel), last_rd[sel]);
      if (!oor) begin
        model[sel][idx] = d;
        known[sel][idx] = 1'b1;
      end
    end else if (oor) begin
      check("rd_oor_zero", get_rdata(sel), 32'd0);
      last_rd[sel] = 32'd0; last_ok[sel] = 1'b1;
    end else if (known[sel][idx]) begin
      check("rd_data", get_rdata(sel), model[sel][idx]);
      last_rd[sel] = model[sel][idx]; last_ok[sel] = 1'b1;
    end else begin
      last_ok[sel] = 1'b0;
    end
  endtask

  // One request; optionally change the bus inputs right after capture.
  task automatic transact(input int sel, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input bit scramble);
    int lat = 0;
    @(negedge clk);
    drive(sel, 1'b1, a, w, d);
    @(posedge clk); #1;
    if (scramble) drive(sel, 1'b0, a + 32'd1, w, ~d);
    else          drive(sel, 1'b0, a, w, d);
    check("busy_after_req", {31'd0, get_busy(sel)}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (get_ready(sel)) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, wait_of(sel) + 1);
    if (lat != 0) begin
      score(sel, a, w, d);
      @(posedge clk); #1;
      check("ready_one_cycle", {31'd0, get_ready(sel)}, 32'd0);
    end
  endtask

  // Hold a read request for n edges; pulses expected every WAIT+2 edges.
  task automatic hold_test(input int sel, input logic [31:0] a, input int n);
    int p = wait_of(sel) + 2;
    int exp_cnt = 0;
    int pos [$];
    for (int s = 1; s <= n; s += p) exp_cnt++;
    @(negedge clk);
    drive(sel, 1'b1, a, 1'b0, 32'd0);
    for (int e = 1; e <= n + 6; e++) begin
      @(posedge clk); #1;
      if (e == n) drive(sel, 1'b0, a, 1'b0, 32'd0);
      if (get_ready(sel)) begin
        pos.push_back(e);
        score(sel, a, 1'b0, 32'd0);
      end
    end
    check("hold_pulse_count", pos.size(), exp_cnt);
    for (int j = 0; j < pos.size() && j < exp_cnt; j++)
      check("hold_pulse_pos", pos[j], wait_of(sel) + 2 + j * p);
  endtask

  task automatic check_reset_state(input int sel);
    check("rst_ready", {31'd0, get_ready(sel)}, 32'd0);
    check("rst_err",   {31'd0, get_err(sel)},   32'd0);
    check("rst_busy",  {31'd0, get_busy(sel)},  32'd0);
    check("rst_rdata", get_rdata(sel), 32'd0);
    last_rd[sel] = 32'd0;
    last_ok[sel] = 1'b1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    drive(0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back.
    transact(0, 32'h005, 1'b1, 32'hDEADBEEF, 1'b0);
    transact(0, 32'h005, 1'b0, 32'h0, 1'b0);

    // Out-of-range read and write; location 0 untouched.
    transact(0, 32'h000, 1'b1, 32'hCAFEF00D, 1'b0);
    transact(0, 32'h400, 1'b0, 32'h0, 1'b0);
    transact(0, 32'h400, 1'b1, 32'h12345678, 1'b0);
    transact(0, 32'h000, 1'b0, 32'h0, 1'b0);

    // Continuous request: ignored while busy.
    transact(0, 32'h010, 1'b1, 32'h0BADC0DE, 1'b0);
    hold_test(0, 32'h010, 12);

    // Inputs changed after capture.
    transact(0, 32'h021, 1'b1, 32'h33333333, 1'b0);
    transact(0, 32'h020, 1'b1, 32'hA5A5A5A5, 1'b1);
    transact(0, 32'h020, 1'b0, 32'h0, 1'b0);
    transact(0, 32'h021, 1'b0, 32'h0, 1'b0);

    // Reset during WAIT_ST aborts the write.
    transact(0, 32'h030, 1'b1, 32'h22222222, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'h030, 1'b1, 32'h11111111);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h030, 1'b1, 32'h11111111);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state(0);
    check_reset_state(1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (get_ready(0)) seen++;
    end
    check("abort_no_ready", seen, 0);
    transact(0, 32'h030, 1'b0, 32'h0, 1'b0);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 32'h005, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("rst_prio_busy", {31'd0, get_busy(0)}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 32'h005, 1'b0, 32'h0);
    last_rd[0] = 32'd0; last_ok[0] = 1'b1;
    last_rd[1] = 32'd0; last_ok[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (get_ready(0)) seen++;
    end
    check("rst_prio_no_ready", seen, 0);

    // Zero-wait instance.
    transact(1, 32'h007, 1'b1, 32'h76543210, 1'b0);
    transact(1, 32'h007, 1'b0, 32'h0, 1'b0);
    transact(1, 32'h008, 1'b1, 32'h5A5A0F0F, 1'b0);
    hold_test(1, 32'h008, 6);

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      int          sel = int'($urandom_range(0, 1));
      logic [31:0] a   = 32'($urandom_range(0, 15));
      logic        w   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 10);
      transact(sel, a, w, 32'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
